// File: rtl/multi_rate_tick_gen.sv
// -----------------------------------------------------------------------------
// multi_rate_tick_gen
//   Generates NUM_CH independent clock-enable ticks from the board clock.
//   Each channel has a run-time programmable divide ratio D, its own count
//   enable and a square-wave output that toggles on every tick (period 2*D).
//
//   Ports
//     clk      in   board clock, rising edge
//     rst      in   asynchronous, active-low reset
//     enable   in   [NUM_CH-1:0] per-channel count enable
//     sync_clr in   restart all channels in phase (commits pending ratios)
//     cfg_wr   in   write strobe for cfg_ch / cfg_div
//     cfg_ch   in   [CH_W-1:0] channel index to write
//     cfg_div  in   [CNT_W-1:0] new divide ratio D (must be >= 1)
//     tick     out  [NUM_CH-1:0] registered one-cycle pulse every D enabled cycles
//     sq_out   out  [NUM_CH-1:0] registered level, toggles on every tick
//     cfg_err  out  registered one-cycle pulse when a write is rejected
//
//   Build option
//     TICK_GEN_CASCADE_EN : when defined, channel i>0 advances only on cycles
//                           where enable[i] and tick[i-1] are both high.
//
//   Handshake: cfg_wr is a single-cycle strobe with no back-pressure; every
//   strobe is either accepted (shadow loaded) or rejected (cfg_err next edge).
// -----------------------------------------------------------------------------
module multi_rate_tick_gen #(
   parameter int                NUM_CH      = 4,
   parameter int                CNT_W       = 32,
   parameter logic [CNT_W-1:0]  DEFAULT_DIV = CNT_W'(100_000_000),
   localparam int               CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] enable,
   input  logic              sync_clr,
   input  logic              cfg_wr,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] sq_out,
   output logic              cfg_err
);

   logic [CNT_W-1:0]  cnt_q    [NUM_CH];
   logic [CNT_W-1:0]  cnt_d    [NUM_CH];
   logic [CNT_W-1:0]  div_q    [NUM_CH];
   logic [CNT_W-1:0]  div_d    [NUM_CH];
   logic [CNT_W-1:0]  shadow_q [NUM_CH];
   logic [CNT_W-1:0]  shadow_d [NUM_CH];
   logic [NUM_CH-1:0] pend_q, pend_d;
   logic [NUM_CH-1:0] tick_q, tick_d;
   logic [NUM_CH-1:0] sq_q, sq_d;
   logic              cfg_err_q, cfg_err_d;

   logic [NUM_CH-1:0] adv;
   logic [NUM_CH-1:0] wrap;
   logic [NUM_CH-1:0] wr_hit;
   logic              wr_ok;

   // Per-channel advance qualifier.
`ifdef TICK_GEN_CASCADE_EN
   // Shifting the registered ticks up by one lines tick[i-1] up with channel i;
   // channel 0 gets a constant 1 so it is gated by its own enable only.
   always_comb adv = enable & ((tick_q << 1) | NUM_CH'(1));
`else
   always_comb adv = enable;
`endif

   // A write is accepted only with a non-zero ratio and an existing channel.
   always_comb wr_ok = cfg_wr && (cfg_div != '0) && (int'(cfg_ch) < NUM_CH);

   always_comb begin
      wrap   = '0;
      wr_hit = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         // Compare against div-1 so D = 2^CNT_W-1 never needs an extra bit.
         wrap[i]   = adv[i] && (cnt_q[i] == div_q[i] - CNT_W'(1));
         wr_hit[i] = wr_ok && (cfg_ch == CH_W'(i));
      end
   end

   always_comb begin
      cfg_err_d = cfg_wr && !wr_ok;
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i]    = cnt_q[i];
         div_d[i]    = div_q[i];
         shadow_d[i] = shadow_q[i];
         pend_d[i]   = pend_q[i];
         tick_d[i]   = 1'b0;
         sq_d[i]     = sq_q[i];
         if (sync_clr) begin
            cnt_d[i]  = '0;
            sq_d[i]   = 1'b0;
            pend_d[i] = 1'b0;
            if (pend_q[i]) div_d[i] = shadow_q[i];
            // A write alongside the clear lands after it and takes effect now.
            if (wr_hit[i]) begin
               shadow_d[i] = cfg_div;
               div_d[i]    = cfg_div;
            end
         end else begin
            if (adv[i]) begin
               if (wrap[i]) begin
                  cnt_d[i]  = '0;
                  tick_d[i] = 1'b1;
                  sq_d[i]   = ~sq_q[i];
                  // Only a value pending before this cycle commits here, so a
                  // running period always completes with the ratio it began with.
                  if (pend_q[i]) begin
                     div_d[i]  = shadow_q[i];
                     pend_d[i] = 1'b0;
                  end
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            if (wr_hit[i]) begin
               shadow_d[i] = cfg_div;
               if (enable[i]) begin
                  pend_d[i] = 1'b1;
               end else begin
                  // Idle channel: nothing to protect, apply immediately.
                  div_d[i]  = cfg_div;
                  cnt_d[i]  = '0;
                  pend_d[i] = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]    <= '0;
            div_q[i]    <= DEFAULT_DIV;
            shadow_q[i] <= DEFAULT_DIV;
         end
         pend_q    <= '0;
         tick_q    <= '0;
         sq_q      <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         shadow_q  <= shadow_d;
         pend_q    <= pend_d;
         tick_q    <= tick_d;
         sq_q      <= sq_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign tick    = tick_q;
   assign sq_out  = sq_q;
   assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_multi_rate_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_multi_rate_tick_gen
//   Directed bench for multi_rate_tick_gen. Main instance: NUM_CH=4, CNT_W=8,
//   DEFAULT_DIV=5. A second 3-channel instance exercises the out-of-range
//   channel index, which a 2-bit index cannot express on a 4-channel build.
//   Edges are numbered from reset release; outputs are sampled on the falling
//   edge and inputs are changed there as well.
// -----------------------------------------------------------------------------
module tb_multi_rate_tick_gen;

   // ---------------- clock / reset ----------------
   logic       clk;
   logic       rst;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- main DUT ----------------
   logic [3:0] enable;
   logic       sync_clr;
   logic       cfg_wr;
   logic [1:0] cfg_ch;
   logic [7:0] cfg_div;
   logic [3:0] tick;
   logic [3:0] sq_out;
   logic       cfg_err;

   multi_rate_tick_gen #(
      .NUM_CH      (4),
      .CNT_W       (8),
      .DEFAULT_DIV (8'd5)
   ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .sync_clr (sync_clr),
      .cfg_wr   (cfg_wr),
      .cfg_ch   (cfg_ch),
      .cfg_div  (cfg_div),
      .tick     (tick),
      .sq_out   (sq_out),
      .cfg_err  (cfg_err)
   );

   // ---------------- 3-channel DUT ----------------
   logic [2:0] enable3;
   logic       sync_clr3;
   logic       cfg_wr3;
   logic [1:0] cfg_ch3;
   logic [7:0] cfg_div3;
   logic [2:0] tick3;
   logic [2:0] sq3;
   logic       err3;

   multi_rate_tick_gen #(
      .NUM_CH      (3),
      .CNT_W       (8),
      .DEFAULT_DIV (8'd5)
   ) u_dut3 (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable3),
      .sync_clr (sync_clr3),
      .cfg_wr   (cfg_wr3),
      .cfg_ch   (cfg_ch3),
      .cfg_div  (cfg_div3),
      .tick     (tick3),
      .sq_out   (sq3),
      .cfg_err  (err3)
   );

   // ---------------- scoreboard ----------------
   int         n_checks = 0;
   int         n_fail   = 0;
   int         edge_n   = 0;
   logic [3:0] exp_tick [0:127];
   logic       exp_err  [0:127];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic next_edge();
      @(negedge clk);
      edge_n++;
   endtask

   // Advance to edge 'last', checking tick and cfg_err against the tables.
   task automatic run_to(input int last);
      while (edge_n < last) begin
         next_edge();
         check("tick", 32'(tick), 32'(exp_tick[edge_n]));
         check("cfg_err", 32'(cfg_err), 32'(exp_err[edge_n]));
      end
   endtask

   task automatic cfg_write(input logic [1:0] ch, input logic [7:0] d);
      cfg_wr  = 1'b1;
      cfg_ch  = ch;
      cfg_div = d;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      $display("FAIL watchdog edge=%0d got=timeout exp=finish", edge_n);
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [3:0] e6;

      for (int i = 0; i < 128; i++) begin
         exp_tick[i] = 4'h0;
         exp_err[i]  = 1'b0;
      end
      // Hand-derived tick vectors (bit i = channel i).
      exp_tick[5]  = 4'hF; exp_tick[10] = 4'hF; exp_tick[15] = 4'hF;
      exp_tick[20] = 4'hF; exp_tick[23] = 4'h2; exp_tick[25] = 4'hD;
      exp_tick[26] = 4'h2; exp_tick[29] = 4'h2; exp_tick[30] = 4'hD;
      exp_tick[32] = 4'h2; exp_tick[35] = 4'hF; exp_tick[38] = 4'h2;
      exp_tick[40] = 4'h9; exp_tick[41] = 4'h2; exp_tick[44] = 4'h6;
      exp_tick[45] = 4'h9; exp_tick[47] = 4'h2; exp_tick[49] = 4'h4;
      exp_tick[50] = 4'hB; exp_tick[53] = 4'h2; exp_tick[54] = 4'h4;
      exp_tick[59] = 4'hF;
      exp_tick[64] = 4'h8; exp_tick[65] = 4'h7; exp_tick[66] = 4'h9;
      exp_tick[67] = 4'h1; exp_tick[68] = 4'h9; exp_tick[69] = 4'h1;
      exp_tick[70] = 4'hF;
      exp_err[27]  = 1'b1;

      rst       = 1'b1;
      enable    = 4'h0;
      sync_clr  = 1'b0;
      cfg_wr    = 1'b0;
      cfg_ch    = 2'd0;
      cfg_div   = 8'd0;
      enable3   = 3'b000;
      sync_clr3 = 1'b0;
      cfg_wr3   = 1'b0;
      cfg_ch3   = 2'd0;
      cfg_div3  = 8'd0;

      #2 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_tick", 32'(tick), 32'h0);
      check("rst_sq", 32'(sq_out), 32'h0);
      check("rst_err", 32'(cfg_err), 32'h0);
      check("rst_err3", 32'(err3), 32'h0);

`ifndef TICK_GEN_CASCADE_EN
      // Reset release with all channels enabled at D=5.
      rst    = 1'b1;
      enable = 4'hF;
      run_to(5);
      check("sq_e5", 32'(sq_out), 32'hF);
      run_to(10);
      check("sq_e10", 32'(sq_out), 32'h0);
      run_to(16);

      // ch1: ratio 5 -> 3 written at cnt=1; old period finishes first.
      cfg_write(2'd1, 8'd3);
      run_to(17);
      cfg_wr = 1'b0;
      run_to(26);

      // Rejected write (ratio 0) to ch0.
      cfg_write(2'd0, 8'd0);
      run_to(27);
      cfg_wr = 1'b0;
      run_to(28);

      // Out-of-range index on the 3-channel instance, then a valid write.
      cfg_wr3  = 1'b1;
      cfg_ch3  = 2'd3;
      cfg_div3 = 8'd7;
      run_to(29);
      check("err3_bad_ch", 32'(err3), 32'h1);
      cfg_ch3 = 2'd2;
      run_to(30);
      check("err3_pulse_end", 32'(err3), 32'h0);
      cfg_wr3 = 1'b0;
      run_to(31);
      check("err3_ok_write", 32'(err3), 32'h0);
      run_to(36);

      // Hold ch2 for four edges mid-count.
      enable = 4'b1011;
      run_to(40);
      check("sq_hold", 32'(sq_out), 32'h4);
      enable = 4'hF;
      run_to(50);

      // Queue D=4 on all channels, then clear mid-period.
      cfg_write(2'd0, 8'd4);
      run_to(51);
      cfg_write(2'd1, 8'd4);
      run_to(52);
      cfg_write(2'd2, 8'd4);
      run_to(53);
      cfg_write(2'd3, 8'd4);
      run_to(54);
      cfg_wr   = 1'b0;
      sync_clr = 1'b1;
      run_to(55);
      sync_clr = 1'b0;
      check("sq_clr", 32'(sq_out), 32'h0);
      run_to(59);
      check("sq_align", 32'(sq_out), 32'hF);

      // Asynchronous reset mid-period.
      #1 rst = 1'b0;
      #1;
      check("async_tick", 32'(tick), 32'h0);
      check("async_sq", 32'(sq_out), 32'h0);
      run_to(60);

      // Release with ch3 idle and a write to it; then D=1 on ch0.
      rst    = 1'b1;
      enable = 4'b0111;
      cfg_write(2'd3, 8'd2);
      run_to(61);
      cfg_write(2'd0, 8'd1);
      run_to(62);
      cfg_wr = 1'b0;
      enable = 4'hF;
      run_to(67);
      check("sq_e67", 32'(sq_out), 32'h7);
      run_to(70);
`else
      rst = 1'b1;
      @(negedge clk);
`endif

      // Cascade check: ch0 D=2, ch1 D=3 written while idle, then cleared in phase.
      enable = 4'h0;
      next_edge();
      cfg_write(2'd0, 8'd2);
      next_edge();
      cfg_write(2'd1, 8'd3);
      next_edge();
      cfg_wr   = 1'b0;
      sync_clr = 1'b1;
      enable   = 4'b0011;
      next_edge();
      sync_clr = 1'b0;
      check("c6_clr_tick", 32'(tick), 32'h0);
      check("c6_clr_sq", 32'(sq_out), 32'h0);
      for (int k = 1; k <= 14; k++) begin
         next_edge();
         e6    = 4'h0;
         e6[0] = (k % 2 == 0);
`ifdef TICK_GEN_CASCADE_EN
         e6[1] = (k == 7) || (k == 13);
`else
         e6[1] = (k % 3 == 0);
`endif
         check("c6_tick", 32'(tick), 32'(e6));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
